// File: rtl/elastic_memory_responder_pkg.sv
// Shared widths and FSM encoding for the elastic memory responder.
package elastic_memory_responder_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int ADDRESS_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

endpackage

// File: rtl/elastic_memory_responder_bank.sv
// Word storage: one synchronous write port, one combinational read port.
module elastic_memory_bank
   import elastic_memory_responder_pkg::*;
#(
   parameter int DATA_WIDTH  = elastic_memory_responder_pkg::DATA_WIDTH,
   parameter int MEM_DEPTH   = 256,
   parameter int INDEX_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   write_enable,
   input  logic [INDEX_WIDTH-1:0] write_index,
   input  logic [DATA_WIDTH-1:0]  write_data,
   input  logic [INDEX_WIDTH-1:0] read_index,
   output logic [DATA_WIDTH-1:0]  read_data
);

   logic [DATA_WIDTH-1:0] words [MEM_DEPTH];

   // No reset: contents must survive reset_n.
   always_ff @(posedge clk) begin
      if (write_enable) begin
         words[write_index] <= write_data;
      end
   end

   assign read_data = words[read_index];

endmodule

// File: rtl/elastic_memory_responder.sv
// Single-outstanding load/store responder with fixed read latency.
module elastic_memory_responder
   import elastic_memory_responder_pkg::*;
#(
   parameter int DATA_WIDTH    = elastic_memory_responder_pkg::DATA_WIDTH,
   parameter int ADDRESS_WIDTH = elastic_memory_responder_pkg::ADDRESS_WIDTH,
   parameter int MEM_DEPTH     = 256,
   parameter int READ_LATENCY  = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_stop,
   input  logic                     req_write,
   input  logic [ADDRESS_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0]    req_write_data,
   output logic                     resp_valid,
   input  logic                     resp_stop,
   output logic [DATA_WIDTH-1:0]    resp_data
);

   localparam int INDEX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_W       = $clog2(READ_LATENCY + 1);
   localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT =
      (ADDRESS_WIDTH + 1)'(MEM_DEPTH);

   state_t                   state;
   logic [CNT_W-1:0]         count;
   logic                     in_range;
   logic                     accept;
   logic [INDEX_WIDTH-1:0]   index;
   logic [DATA_WIDTH-1:0]    read_data;
   logic [DATA_WIDTH-1:0]    load_word;

   assign accept    = req_valid && (state == IDLE);
   assign in_range  = {1'b0, req_address} < DEPTH_LIMIT;
   assign index     = req_address[INDEX_WIDTH-1:0];
   assign load_word = in_range ? read_data : '0;

   assign req_stop   = (state != IDLE);
   assign resp_valid = (state == RESPOND);

   elastic_memory_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MEM_DEPTH   (MEM_DEPTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_bank (
      .clk          (clk),
      .write_enable (accept && req_write && in_range),
      .write_index  (index),
      .write_data   (req_write_data),
      .read_index   (index),
      .read_data    (read_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         count     <= '0;
         resp_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept && !req_write) begin
                  resp_data <= load_word;
                  if (READ_LATENCY == 1) begin
                     state <= RESPOND;
                  end else begin
                     state <= WAIT;
                     count <= CNT_W'(READ_LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               count <= count - 1'b1;
               if (count == CNT_W'(1)) begin
                  state <= RESPOND;
               end
            end
            RESPOND: begin
               if (!resp_stop) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_elastic_memory_responder.sv
// Random and directed checks of the responder against a word-array model.
module tb_elastic_memory_responder;

   localparam int DW    = 32;
   localparam int AW    = 16;
   localparam int DEPTH = 256;
   localparam int LAT   = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_stop;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_address = '0;
   logic [DW-1:0] req_write_data = '0;
   logic          resp_valid;
   logic          resp_stop = 1'b0;
   logic [DW-1:0] resp_data;

   logic          b_req_valid = 1'b0;
   logic          b_req_stop;
   logic          b_req_write = 1'b0;
   logic [AW-1:0] b_req_address = '0;
   logic [DW-1:0] b_req_write_data = '0;
   logic          b_resp_valid;
   logic          b_resp_stop = 1'b0;
   logic [DW-1:0] b_resp_data;

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] model_b [8];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   elastic_memory_responder #(
      .DATA_WIDTH (DW), .ADDRESS_WIDTH (AW),
      .MEM_DEPTH (DEPTH), .READ_LATENCY (LAT)
   ) dut (
      .clk (clk), .reset_n (reset_n),
      .req_valid (req_valid), .req_stop (req_stop),
      .req_write (req_write), .req_address (req_address),
      .req_write_data (req_write_data),
      .resp_valid (resp_valid), .resp_stop (resp_stop),
      .resp_data (resp_data)
   );

   elastic_memory_responder #(
      .DATA_WIDTH (DW), .ADDRESS_WIDTH (AW),
      .MEM_DEPTH (DEPTH), .READ_LATENCY (1)
   ) dut_lat1 (
      .clk (clk), .reset_n (reset_n),
      .req_valid (b_req_valid), .req_stop (b_req_stop),
      .req_write (b_req_write), .req_address (b_req_address),
      .req_write_data (b_req_write_data),
      .resp_valid (b_resp_valid), .resp_stop (b_resp_stop),
      .resp_data (b_resp_data)
   );

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] expect_load(logic [AW-1:0] a);
      return (a < DEPTH) ? model[a] : '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves req_valid high so consecutive calls issue back-to-back stores.
   task automatic store(logic [AW-1:0] a, logic [DW-1:0] d);
      req_valid      = 1'b1;
      req_write      = 1'b1;
      req_address    = a;
      req_write_data = d;
      check("store_req_stop", req_stop, 1'b0);
      tick();
      if (a < DEPTH) model[a] = d;
   endtask

   // Noise on the request port while busy must be ignored.
   task automatic load(logic [AW-1:0] a, int hold);
      logic [DW-1:0] exp;
      exp         = expect_load(a);
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_address = a;
      resp_stop   = (hold > 0);
      check("load_req_stop", req_stop, 1'b0);
      tick();
      req_write      = 1'b1;
      req_address    = AW'($urandom_range(0, DEPTH - 1));
      req_write_data = $urandom;
      for (int j = 0; j < LAT - 1; j++) begin
         check("wait_resp_valid", resp_valid, 1'b0);
         check("wait_req_stop", req_stop, 1'b1);
         tick();
      end
      check("resp_valid", resp_valid, 1'b1);
      check("resp_data", resp_data, exp);
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", resp_valid, 1'b1);
         check("hold_data", resp_data, exp);
         check("hold_req_stop", req_stop, 1'b1);
      end
      resp_stop = 1'b0;
      tick();
      req_valid = 1'b0;
      check("one_beat", resp_valid, 1'b0);
      check("post_req_stop", req_stop, 1'b0);
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      #2;
      check("rst_req_stop", req_stop, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_data", resp_data, '0);
      tick();
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < DEPTH; i++) store(AW'(i), $urandom);
      req_valid = 1'b0;
      tick();

      store(16'd5, 32'hDEADBEEF);
      req_valid = 1'b0;
      load(16'd5, 0);

      for (int i = 0; i < 4; i++) store(AW'(i), DW'(10 + i));
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) load(AW'(i), 0);

      for (int i = 0; i < 60; i++) begin
         a = AW'($urandom_range(0, 299));
         d = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            store(a, d);
            req_valid = 1'b0;
         end else begin
            load(a, $urandom_range(0, 3));
         end
      end

      load(16'd1, 6);

      load(16'd300, 0);
      store(16'd300, 32'h55);
      req_valid = 1'b0;
      load(16'd300, 0);
      load(16'd44, 0);

      store(16'd7, 32'hCAFE0007);
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_address = 16'd7;
      tick();
      req_valid = 1'b0;
      tick();
      reset_n = 1'b0;
      #1;
      check("arst_req_stop", req_stop, 1'b0);
      check("arst_resp_valid", resp_valid, 1'b0);
      check("arst_resp_data", resp_data, '0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < LAT + 2; i++) begin
         check("no_resp_after_rst", resp_valid, 1'b0);
         tick();
      end
      load(16'd7, 0);
      load(16'd44, 0);

      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         b_req_valid      = 1'b1;
         b_req_write      = 1'b1;
         b_req_address    = AW'(i * 3);
         b_req_write_data = d;
         tick();
         model_b[i]  = d;
         b_req_write = 1'b0;
         b_resp_stop = (i % 2 == 1);
         tick();
         b_req_valid = 1'b0;
         check("lat1_valid", b_resp_valid, 1'b1);
         check("lat1_data", b_resp_data, model_b[i]);
         if (b_resp_stop) begin
            tick();
            check("lat1_hold", b_resp_valid, 1'b1);
            b_resp_stop = 1'b0;
         end
         tick();
         check("lat1_done", b_resp_valid, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
